start_screen_ctrl: RTL and testbench

- Sequences the title screen into gameplay.
- Watches a hand-tracked pointer once per frame; detects dwell on the play button (x 380..579, y 500..599).
- Drives a hold-progress count, then a timed fade-to-black on the composited pixel stream, then hands off to the game screen.
- Sits between the pointer tracker, the start-screen compositor and the top-level screen mux.

---
 rtl/display_pkg.sv | 29 ++
 rtl/pixel_dimmer.sv | 35 +++
 rtl/start_screen_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_start_screen_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display-path types: controller state encoding, screen selector
// values, the RGB888 pixel type and a per-channel brightness scaler.
package display_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        HOVER = 2'd1,
        FADE  = 2'd2,
        GAME  = 2'd3
    } ctrl_state_t;

    localparam logic SCREEN_TITLE = 1'b0;
    localparam logic SCREEN_GAME  = 1'b1;

    typedef logic [23:0] rgb_t;

    // Scale one 8-bit channel by level/256. Full level (8'hFF) is treated as
    // exact unity so an undimmed picture passes through bit-identical.
    function automatic logic [7:0] dim_channel(input logic [7:0] ch,
                                               input logic [7:0] level);
        logic [15:0] prod;
        prod = ch * level;
        if (level == 8'hFF) begin
            return ch;
        end
        return prod[15:8];
    endfunction

endpackage

// File: rtl/pixel_dimmer.sv
// Registered RGB888 dimmer: each channel is multiplied by a common 8-bit
// brightness level. One cycle of latency, every cycle, no enable.
module pixel_dimmer
    import display_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  rgb_t       pixel_in,
    input  logic [7:0] level_in,
    output rgb_t       pixel_out
);

    rgb_t pixel_d;
    rgb_t pixel_q;

    // Three independent 8x8 channel multiplies on the incoming pixel.
    always_comb begin
        pixel_d        = '0;
        pixel_d[23:16] = dim_channel(pixel_in[23:16], level_in);
        pixel_d[15:8]  = dim_channel(pixel_in[15:8],  level_in);
        pixel_d[7:0]   = dim_channel(pixel_in[7:0],   level_in);
    end

    // Output register; cleared to black on reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel_out = pixel_q;

endmodule

// File: rtl/start_screen_ctrl.sv
// Title-screen sequencer. Once per frame it checks whether the tracked
// pointer sits on the play button; a long enough dwell commits to a timed
// fade-to-black of the title picture, after which it hands over to the game
// screen until the game logic reports game over.
//
// Handshake note: there is no valid/ready flow here. frame_tick_in is a
// qualifier pulse: pointer inputs are sampled only on cycles where it is 1,
// and every such cycle is a separate frame. start_game_out is a one-cycle
// strobe with no acknowledge.
module start_screen_ctrl
    import display_pkg::*;
#(
    parameter int unsigned BTN_X       = 380,
    parameter int unsigned BTN_Y       = 500,
    parameter int unsigned BTN_W       = 200,
    parameter int unsigned BTN_H       = 100,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned FADE_LOG2   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic [10:0] pointer_x_in,
    input  logic [9:0]  pointer_y_in,
    input  logic        pointer_valid_in,
    input  logic        game_over_in,
    input  rgb_t        pixel_in,
    output rgb_t        pixel_out,
    output logic        screen_sel_out,
    output logic        hover_out,
    output logic [7:0]  progress_out,
    output logic [7:0]  fade_level_out,
    output logic        start_game_out
);

    // Button bounds widened to 12 bits so edge+size can never wrap.
    localparam logic [11:0] X_LO = 12'(BTN_X);
    localparam logic [11:0] X_HI = 12'(BTN_X + BTN_W);
    localparam logic [11:0] Y_LO = 12'(BTN_Y);
    localparam logic [11:0] Y_HI = 12'(BTN_Y + BTN_H);

    localparam logic [8:0] HOLD_TARGET = 9'(HOLD_FRAMES);
    localparam logic [7:0] FADE_LAST   = 8'((1 << FADE_LOG2) - 1);
    localparam int unsigned FADE_SHIFT = 8 - FADE_LOG2;

    ctrl_state_t state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  fade_q, fade_d;

    logic        hover_q, hover_d;
    logic        sel_q, sel_d;
    logic [7:0]  progress_q, progress_d;
    logic [7:0]  level_q, level_d;
    logic        start_q, start_d;

    logic [11:0] px;
    logic [11:0] py;
    logic        hit;
    logic [8:0]  hold_inc;

    assign px       = {1'b0, pointer_x_in};
    assign py       = {2'b0, pointer_y_in};
    assign hold_inc = {1'b0, hold_q} + 9'd1;

    // Pointer-on-button test; only meaningful on frame tick cycles.
    always_comb begin
        hit = pointer_valid_in
            & (px >= X_LO) & (px < X_HI)
            & (py >= Y_LO) & (py < Y_HI);
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fade_d  = fade_q;
        start_d = 1'b0;

        unique case (state_q)
            START: begin
                if (frame_tick_in) begin
                    if (hit) begin
                        if (HOLD_TARGET == 9'd1) begin
                            state_d = FADE;
                            hold_d  = 8'd0;
                            fade_d  = 8'd0;
                        end else begin
                            state_d = HOVER;
                            hold_d  = 8'd1;
                        end
                    end else begin
                        hold_d = 8'd0;
                    end
                end
            end
            HOVER: begin
                if (frame_tick_in) begin
                    if (!hit) begin
                        state_d = START;
                        hold_d  = 8'd0;
                    end else if (hold_inc == HOLD_TARGET) begin
                        state_d = FADE;
                        hold_d  = 8'd0;
                        fade_d  = 8'd0;
                    end else begin
                        hold_d = hold_inc[7:0];
                    end
                end
            end
            FADE: begin
                // Committed: the pointer no longer matters.
                if (frame_tick_in) begin
                    if (fade_q == FADE_LAST) begin
                        state_d = GAME;
                        fade_d  = 8'd0;
                        start_d = 1'b1;
                    end else begin
                        fade_d = fade_q + 8'd1;
                    end
                end
            end
            GAME: begin
                // game_over_in takes priority over anything else this cycle.
                if (game_over_in) begin
                    state_d = START;
                    hold_d  = 8'd0;
                    fade_d  = 8'd0;
                end
            end
            default: begin
                state_d = START;
                hold_d  = 8'd0;
                fade_d  = 8'd0;
            end
        endcase

        hover_d    = (state_d == HOVER);
        sel_d      = (state_d == GAME) ? SCREEN_GAME : SCREEN_TITLE;
        progress_d = (state_d == HOVER) ? hold_d : 8'd0;
        level_d    = (state_d == FADE) ? (8'hFF - (fade_d << FADE_SHIFT)) : 8'hFF;
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= START;
            hold_q     <= 8'd0;
            fade_q     <= 8'd0;
            hover_q    <= 1'b0;
            sel_q      <= SCREEN_TITLE;
            progress_q <= 8'd0;
            level_q    <= 8'hFF;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            fade_q     <= fade_d;
            hover_q    <= hover_d;
            sel_q      <= sel_d;
            progress_q <= progress_d;
            level_q    <= level_d;
            start_q    <= start_d;
        end
    end

    // The registered fade level drives the dimmer, so pixel_out reflects the
    // level shown on fade_level_out in the previous cycle.
    pixel_dimmer u_dimmer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .pixel_in  (pixel_in),
        .level_in  (level_q),
        .pixel_out (pixel_out)
    );

    assign hover_out      = hover_q;
    assign screen_sel_out = sel_q;
    assign progress_out   = progress_q;
    assign fade_level_out = level_q;
    assign start_game_out = start_q;

endmodule

// File: tb/tb_start_screen_ctrl.sv
// Bench for start_screen_ctrl: hit-test vector table, hand sequences for
// dwell / abort / fade / return / mid-fade reset, then randomized traffic
// against a frame-level reference model.
module tb_start_screen_ctrl;

    localparam int HOLD = 30;
    localparam int FLEN = 16;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        frame_tick_in;
    logic [10:0] pointer_x_in;
    logic [9:0]  pointer_y_in;
    logic        pointer_valid_in;
    logic        game_over_in;
    logic [23:0] pixel_in;
    logic [23:0] pixel_out;
    logic        screen_sel_out;
    logic        hover_out;
    logic [7:0]  progress_out;
    logic [7:0]  fade_level_out;
    logic        start_game_out;

    always #5 clk_in = ~clk_in;

    start_screen_ctrl dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .frame_tick_in    (frame_tick_in),
        .pointer_x_in     (pointer_x_in),
        .pointer_y_in     (pointer_y_in),
        .pointer_valid_in (pointer_valid_in),
        .game_over_in     (game_over_in),
        .pixel_in         (pixel_in),
        .pixel_out        (pixel_out),
        .screen_sel_out   (screen_sel_out),
        .hover_out        (hover_out),
        .progress_out     (progress_out),
        .fade_level_out   (fade_level_out),
        .start_game_out   (start_game_out)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // streak: consecutive hit frames while on the title screen
    // fade  : frames elapsed in the fade, -1 when not fading
    // game  : 1 while the game screen is shown
    int          m_streak = 0;
    int          m_fade   = -1;
    bit          m_game   = 1'b0;
    logic [23:0] m_pix    = '0;
    bit          m_start  = 1'b0;

    function automatic int m_level();
        if (m_fade >= 0) return 255 - m_fade * (256 / FLEN);
        return 255;
    endfunction

    function automatic logic [7:0] m_dim(input logic [7:0] c, input int lvl);
        if (lvl == 255) return c;
        return 8'((int'(c) * lvl) / 256);
    endfunction

    function automatic bit m_hit(input int x, input int y, input bit v);
        return v && x >= 380 && x < 580 && y >= 500 && y < 600;
    endfunction

    task automatic compare_all();
        check("hover",    32'(hover_out),      32'(m_fade < 0 && !m_game && m_streak > 0));
        check("progress", 32'(progress_out),   (m_fade < 0 && !m_game) ? m_streak : 0);
        check("sel",      32'(screen_sel_out), 32'(m_game));
        check("level",    32'(fade_level_out), m_level());
        check("start",    32'(start_game_out), 32'(m_start));
        check("pixel",    32'(pixel_out),      32'(m_pix));
    endtask

    // ---------------- driver ----------------
    logic [23:0] cur_pix = 24'h123456;
    int          start_seen = 0;

    task automatic step(input bit tick, input int x, input int y, input bit v,
                        input bit go, input bit r, input logic [23:0] pix);
        int lvl_prev;
        frame_tick_in    = tick;
        pointer_x_in     = 11'(x);
        pointer_y_in     = 10'(y);
        pointer_valid_in = v;
        game_over_in     = go;
        rst_in           = r;
        pixel_in         = pix;
        @(posedge clk_in);
        #1;
        lvl_prev = m_level();
        if (r) begin
            m_streak = 0; m_fade = -1; m_game = 0; m_pix = '0; m_start = 0;
        end else begin
            m_pix   = {m_dim(pix[23:16], lvl_prev), m_dim(pix[15:8], lvl_prev), m_dim(pix[7:0], lvl_prev)};
            m_start = 0;
            if (m_game) begin
                if (go) begin m_game = 0; m_streak = 0; end
            end else if (m_fade >= 0) begin
                if (tick) begin
                    m_fade++;
                    if (m_fade == FLEN) begin m_fade = -1; m_game = 1; m_start = 1; end
                end
            end else if (tick) begin
                if (m_hit(x, y, v)) begin
                    m_streak++;
                    if (m_streak == HOLD) begin m_streak = 0; m_fade = 0; end
                end else begin
                    m_streak = 0;
                end
            end
        end
        if (start_game_out === 1'b1) start_seen++;
        compare_all();
    endtask

    task automatic tk(input int x, input int y, input bit v);
        step(1'b1, x, y, v, 1'b0, 1'b0, cur_pix);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, cur_pix);
    endtask

    task automatic do_reset();
        step(1'b1, 400, 520, 1'b1, 1'b1, 1'b1, cur_pix);
    endtask

    // ---------------- hit-test vector table ----------------
    typedef struct {
        int x;
        int y;
        bit v;
        bit hit;
    } hit_vec_t;

    hit_vec_t hv[10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        rst_in = 1'b1; frame_tick_in = 0; pointer_x_in = 0; pointer_y_in = 0;
        pointer_valid_in = 0; game_over_in = 0; pixel_in = '0;

        hv[0] = '{380, 500, 1'b1, 1'b1};
        hv[1] = '{379, 500, 1'b1, 1'b0};
        hv[2] = '{579, 599, 1'b1, 1'b1};
        hv[3] = '{580, 500, 1'b1, 1'b0};
        hv[4] = '{380, 600, 1'b1, 1'b0};
        hv[5] = '{380, 499, 1'b1, 1'b0};
        hv[6] = '{400, 520, 1'b0, 1'b0};
        hv[7] = '{2047, 1023, 1'b1, 1'b0};
        hv[8] = '{479, 550, 1'b1, 1'b1};
        hv[9] = '{0, 0, 1'b1, 1'b0};

        // Reset hold with pointer on the button and ticks running.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 400, 520, 1'b1, 1'b0, 1'b1, cur_pix);
            check("rst_level", 32'(fade_level_out), 32'hFF);
            check("rst_progress", 32'(progress_out), 0);
            check("rst_hover", 32'(hover_out), 0);
            check("rst_pixel", 32'(pixel_out), 0);
        end
        idle();

        // Hit-test table: one tick from a clean START.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            tk(hv[i].x, hv[i].y, hv[i].v);
            check($sformatf("hit_vec%0d_hover", i), 32'(hover_out), 32'(hv[i].hit));
            check($sformatf("hit_vec%0d_prog", i), 32'(progress_out), hv[i].hit ? 1 : 0);
        end

        // Right edge is exclusive: repeated ticks never hover.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tk(580, 500, 1'b1);
            check("right_edge_hover", 32'(hover_out), 0);
        end

        // Abort: 10 hits, one tick without lock, then a fresh hit.
        do_reset();
        for (int i = 0; i < 10; i++) tk(450, 550, 1'b1);
        check("abort_pre_progress", 32'(progress_out), 10);
        tk(450, 550, 1'b0);
        check("abort_progress", 32'(progress_out), 0);
        check("abort_hover", 32'(hover_out), 0);
        tk(450, 550, 1'b1);
        check("abort_restart_progress", 32'(progress_out), 1);

        // Dwell to select, then fade to game.
        do_reset();
        start_seen = 0;
        for (int i = 1; i <= HOLD; i++) begin
            tk(380, 500, 1'b1);
            if (i < HOLD) check($sformatf("dwell_progress%0d", i), 32'(progress_out), i);
        end
        check("select_hover", 32'(hover_out), 0);
        check("select_level", 32'(fade_level_out), 32'hFF);
        cur_pix = 24'hFF8040;
        idle();
        tk(0, 0, 1'b0);
        check("fade1_level", 32'(fade_level_out), 32'hEF);
        idle();
        check("fade1_pixel", 32'(pixel_out), 32'hEE773B);
        for (int i = 2; i <= 15; i++) tk(0, 0, 1'b0);
        check("fade15_level", 32'(fade_level_out), 32'h0F);
        check("fade15_sel", 32'(screen_sel_out), 0);
        tk(0, 0, 1'b0);
        check("game_sel", 32'(screen_sel_out), 1);
        check("game_start_pulse", 32'(start_game_out), 1);
        idle();
        check("game_start_drop", 32'(start_game_out), 0);
        check("game_pixel_pass", 32'(pixel_out), 32'hFF8040);
        check("game_start_count", 32'(start_seen), 1);

        // Return: game over together with a hit tick.
        step(1'b1, 400, 520, 1'b1, 1'b1, 1'b0, cur_pix);
        check("return_sel", 32'(screen_sel_out), 0);
        check("return_hover", 32'(hover_out), 0);
        check("return_level", 32'(fade_level_out), 32'hFF);

        // Mid-fade reset at fade tick 8.
        do_reset();
        for (int i = 0; i < HOLD; i++) tk(500, 550, 1'b1);
        for (int i = 0; i < 7; i++) tk(500, 550, 1'b1);
        start_seen = 0;
        step(1'b1, 500, 550, 1'b1, 1'b0, 1'b1, cur_pix);
        check("midfade_rst_level", 32'(fade_level_out), 32'hFF);
        for (int i = 0; i < 40; i++) tk(100, 100, 1'b1);
        check("midfade_no_start", 32'(start_seen), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            bit sticky;
            sticky = (blk % 2) == 0;
            for (int i = 0; i < 500; i++) begin
                bit tick, v, go, r, inbox;
                int x, y;
                tick  = ($urandom_range(0, 2) == 0);
                inbox = sticky ? ($urandom_range(0, 99) < 98) : ($urandom_range(0, 1) == 0);
                v     = sticky ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 9) != 0);
                if (inbox) begin
                    x = $urandom_range(380, 579);
                    y = $urandom_range(500, 599);
                end else begin
                    x = $urandom_range(0, 2047);
                    y = $urandom_range(0, 1023);
                end
                go = ($urandom_range(0, 29) == 0);
                r  = ($urandom_range(0, 599) == 0);
                cur_pix = 24'($urandom);
                step(tick, x, y, v, go, r, cur_pix);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
